// File: rtl/risc_pkg.sv
// Shared SoC definitions: bus widths, boot-loader state encoding and status decode.
package risc_pkg;

  localparam int IMEM_ADDR_W = 16;
  localparam int WORD_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_LO = 3'd1,
    S_LOAD_HI = 3'd2,
    S_WRITE   = 3'd3,
    S_RUN     = 3'd4,
    S_HALTED  = 3'd5,
    S_ERROR   = 3'd6
  } loader_state_t;

  typedef struct packed {
    logic s_ready;
    logic core_rst_n;
    logic busy;
    logic done;
    logic error;
  } loader_flags_t;

  // Status outputs as a pure function of state; the FSM registers them from the next state.
  function automatic loader_flags_t decode_flags(loader_state_t st);
    loader_flags_t f;
    f            = '0;
    f.s_ready    = (st == S_LOAD_LO) || (st == S_LOAD_HI);
    f.core_rst_n = (st == S_RUN) || (st == S_HALTED);
    f.busy       = (st == S_LOAD_LO) || (st == S_LOAD_HI) || (st == S_WRITE);
    f.done       = (st == S_RUN) || (st == S_HALTED);
    f.error      = (st == S_ERROR);
    return f;
  endfunction

endpackage

// File: rtl/loader_byte_packer.sv
// Assembles two stream bytes (low first) into one word and emits a one-cycle word pulse.
module loader_byte_packer
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              lo_en,
  input  logic              hi_en,
  input  logic [7:0]        data,
  input  logic              last,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              word_last
);

  logic [7:0] lo_byte;
  logic [7:0] hi_byte;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_byte    <= '0;
      hi_byte    <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
    end else begin
      word_valid <= hi_en;
      if (lo_en) lo_byte <= data;
      if (hi_en) begin
        hi_byte   <= data;
        word_last <= last;
      end
    end
  end

  assign word = {hi_byte, lo_byte};

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader into IMEM; holds the core in reset until loaded, then watches halt.
// Optional trailing checksum word enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
  import risc_pkg::*;
#(
  parameter int IMEM_SIZE = 64,
  parameter int ADDR_W    = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              imem_wr,
  output logic              core_rst_n,
  input  logic              core_holt,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  loader_state_t state, state_n;
  loader_flags_t flags;
  logic [WORD_W-1:0] pk_word;
  logic pk_valid, pk_last;
  logic hs, lo_en, hi_en, overflow, chk_word, chk_ok, start_load;

  assign hs         = s_valid & flags.s_ready;
  assign start_load = start && (state == S_IDLE || state == S_HALTED || state == S_ERROR);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum;

  // The word closing the stream is the checksum: never written, never counted.
  assign chk_word = s_last;
  assign chk_ok   = (sum == pk_word);

  always_ff @(posedge clk) begin
    if (rst || start_load) sum <= '0;
    else if (imem_wr)      sum <= sum + pk_word;
  end
`else
  assign chk_word = 1'b0;
  assign chk_ok   = 1'b1;
`endif

  assign overflow = (word_count == 16'(IMEM_SIZE)) && !chk_word;
  assign lo_en    = hs && (state == S_LOAD_LO);
  assign hi_en    = hs && (state == S_LOAD_HI) && !overflow;

  loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .lo_en      (lo_en),
    .hi_en      (hi_en),
    .data       (s_data),
    .last       (s_last),
    .word       (pk_word),
    .word_valid (pk_valid),
    .word_last  (pk_last)
  );

  // NOTE: state_n gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_HALTED, S_ERROR: if (start) state_n = S_LOAD_LO;
      S_LOAD_LO: if (hs) state_n = s_last ? S_ERROR : S_LOAD_HI;
      S_LOAD_HI: if (hs) state_n = overflow ? S_ERROR : S_WRITE;
      S_WRITE: begin
        if (pk_valid && pk_last) state_n = chk_ok ? S_RUN : S_ERROR;
        else                     state_n = S_LOAD_LO;
      end
      S_RUN:   if (core_holt) state_n = S_HALTED;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      flags      <= '0;
      imem_wr    <= 1'b0;
      imem_waddr <= '0;
      word_count <= '0;
    end else begin
      state   <= state_n;
      flags   <= decode_flags(state_n);
      imem_wr <= hi_en && !chk_word;
      if (hi_en)        imem_waddr <= ADDR_W'(word_count);
      if (start_load)   word_count <= '0;
      else if (imem_wr) word_count <= word_count + 16'd1;
    end
  end

  assign imem_wdata = pk_word;
  assign s_ready    = flags.s_ready;
  assign core_rst_n = flags.core_rst_n;
  assign busy       = flags.busy;
  assign done       = flags.done;
  assign error      = flags.error;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (default build, or checksum build when
// IMEM_LOADER_CHECKSUM_EN is defined).
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_last, core_holt;
  logic [7:0]  s_data;
  logic        s_ready, imem_wr, core_rst_n, busy, done, error;
  logic [15:0] imem_waddr, imem_wdata, word_count;

  int errors = 0;
  int checks = 0;
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .imem_wr    (imem_wr),
    .core_rst_n (core_rst_n),
    .core_holt  (core_holt),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always @(negedge clk) begin
    if (imem_wr === 1'b1) begin
      wr_addr_q.push_back(imem_waddr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (s_ready) ok = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (!ok) check("handshake_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; core_holt = 1'b0;
    tick(); tick();
    check("rst_core_rst_n", 32'(core_rst_n), 0);
    check("rst_s_ready",    32'(s_ready),    0);
    check("rst_busy",       32'(busy),       0);
    check("rst_done",       32'(done),       0);
    check("rst_error",      32'(error),      0);
    check("rst_imem_wr",    32'(imem_wr),    0);
    check("rst_word_count", 32'(word_count), 0);
    check("rst_wdata",      32'(imem_wdata), 0);
    rst = 1'b0;
    tick();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // 0x0001 + 0xFFFF wraps to 0x0000: matching checksum.
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 1);
    check("chk_word_not_written", 32'(imem_wr), 0);
    tick();
    check("chk_ok_done",       32'(done),          1);
    check("chk_ok_core_rst_n", 32'(core_rst_n),    1);
    check("chk_ok_word_count", 32'(word_count),    2);
    check("chk_ok_writes",     wr_addr_q.size(),   2);
    check("chk_ok_data1",      32'(wr_data_q[1]),  32'hFFFF);
    core_holt = 1'b1; tick(); core_holt = 1'b0;
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    send_byte(8'h01, 0); send_byte(8'h00, 1);
    tick();
    check("chk_bad_error",      32'(error),      1);
    check("chk_bad_core_rst_n", 32'(core_rst_n), 0);
    check("chk_bad_word_count", 32'(word_count), 2);
    // Checksum-only stream: nothing written, expected sum is zero.
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 1);
    tick();
    check("chk_only_done",       32'(done),        1);
    check("chk_only_word_count", 32'(word_count),  0);
    check("chk_only_writes",     wr_addr_q.size(), 4);
`else
    // Two-word program.
    pulse_start();
    check("start_busy",    32'(busy),    1);
    check("start_s_ready", 32'(s_ready), 1);
    send_byte(8'h34, 0); send_byte(8'h12, 0);
    check("w0_wr",    32'(imem_wr),    1);
    check("w0_addr",  32'(imem_waddr), 0);
    check("w0_data",  32'(imem_wdata), 32'h1234);
    send_byte(8'h78, 0); send_byte(8'h56, 1);
    check("w1_wr",         32'(imem_wr),    1);
    check("w1_addr",       32'(imem_waddr), 1);
    check("w1_data",       32'(imem_wdata), 32'h5678);
    check("w1_core_rst_n", 32'(core_rst_n), 0);
    tick();
    check("run_core_rst_n", 32'(core_rst_n), 1);
    check("run_done",       32'(done),       1);
    check("run_word_count", 32'(word_count), 2);
    check("run_writes",     wr_addr_q.size(), 2);
    pulse_start();
    check("run_start_ignored", 32'(busy), 0);
    core_holt = 1'b1; tick(); core_holt = 1'b0;
    check("halt_done",       32'(done),       1);
    check("halt_core_rst_n", 32'(core_rst_n), 1);
    pulse_start();
    check("restart_busy",       32'(busy),       1);
    check("restart_word_count", 32'(word_count), 0);
    check("restart_core_rst_n", 32'(core_rst_n), 0);

    // Odd byte count: one word written, then error on the dangling low byte.
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    check("odd_w0_data", 32'(imem_wdata), 32'hBBAA);
    send_byte(8'hCC, 1);
    check("odd_error",      32'(error),      1);
    check("odd_core_rst_n", 32'(core_rst_n), 0);
    check("odd_s_ready",    32'(s_ready),    0);
    check("odd_word_count", 32'(word_count), 1);

    // Overflow: 64 words fill IMEM, the 65th hi byte is rejected.
    pulse_start();
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < 64; i++) begin
      send_byte(8'(i), 0);
      send_byte(~8'(i), 0);
    end
    send_byte(8'hEE, 0);
    send_byte(8'hDD, 0);
    check("ovf_error",      32'(error),      1);
    check("ovf_word_count", 32'(word_count), 64);
    tick();
    check("ovf_writes",     wr_addr_q.size(),    64);
    check("ovf_last_addr",  32'(wr_addr_q[63]),  63);
    check("ovf_last_data",  32'(wr_data_q[63]),  32'hC03F);
    check("ovf_first_data", 32'(wr_data_q[0]),   32'hFF00);

    // Reset in LOAD_HI with a hi byte offered: no write, everything back to zero.
    pulse_start();
    send_byte(8'h11, 0);
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h22;
    tick();
    rst = 1'b0; s_valid = 1'b0;
    check("mid_rst_busy",    32'(busy),       0);
    check("mid_rst_s_ready", 32'(s_ready),    0);
    check("mid_rst_imem_wr", 32'(imem_wr),    0);
    check("mid_rst_waddr",   32'(imem_waddr), 0);
    check("mid_rst_wdata",   32'(imem_wdata), 0);
    check("mid_rst_core",    32'(core_rst_n), 0);
    tick(); tick();
    check("mid_rst_no_write", wr_addr_q.size(), 64);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
